// File: rtl/button_input_peripheral_if.sv
// Processor bus bundle for the button/switch input peripheral.
// The slave side answers reads with registered data and raises irq.
interface button_input_peripheral_if;
   logic        sel;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (
      output sel, we, addr, wdata,
      input  rdata, irq
   );

   modport slave (
      input  sel, we, addr, wdata,
      output rdata, irq
   );
endinterface

// File: rtl/button_input_peripheral.sv
// Button/switch input peripheral: synchronizers, debouncer, sticky press flag and counter.
// Optional press interrupt enabled by defining BUTTON_IRQ_EN.
module button_input_peripheral #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        button_n,
   input  logic [9:0]  switches,
   button_input_peripheral_if.slave bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_meta_n;
   logic             btn_sync_n;
   logic             btn_stable_n;
   logic             btn_prev_n;
   logic [DB_W-1:0]  db_cnt;
   logic [9:0]       sw_meta;
   logic [9:0]       sw_sync;
   logic             pending;
   logic [CNT_W-1:0] count;
   logic             irq_enable;
   logic             press;
   logic             rd;
   logic             wr;
   logic [31:0]      status;

   assign press = btn_prev_n & ~btn_stable_n;
   assign rd    = bus.sel & ~bus.we;
   assign wr    = bus.sel & bus.we;

   assign status = {29'd0, irq_enable, pending, ~btn_stable_n};

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_meta_n   <= 1'b1;
         btn_sync_n   <= 1'b1;
         btn_stable_n <= 1'b1;
         btn_prev_n   <= 1'b1;
         db_cnt       <= '0;
         sw_meta      <= '0;
         sw_sync      <= '0;
      end else begin
         btn_meta_n <= button_n;
         btn_sync_n <= btn_meta_n;
         sw_meta    <= switches;
         sw_sync    <= sw_meta;
         btn_prev_n <= btn_stable_n;
         // Only an unbroken run of differing samples moves the stable level.
         if (btn_sync_n == btn_stable_n) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_stable_n <= btn_sync_n;
            db_cnt       <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= 1'b0;
         count   <= '0;
      end else begin
         if (press) begin
            pending <= 1'b1;
         end else if (wr && bus.addr == 2'd0 && bus.wdata[1]) begin
            pending <= 1'b0;
         end
         if (wr && bus.addr == 2'd1) begin
            count <= press ? CNT_W'(1) : '0;
         end else if (press && count != '1) begin
            count <= count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rdata <= '0;
      end else if (rd) begin
         unique case (bus.addr)
            2'd0:    bus.rdata <= status;
            2'd1:    bus.rdata <= 32'(count);
            2'd2:    bus.rdata <= {22'd0, sw_sync};
            default: bus.rdata <= '0;
         endcase
      end
   end

`ifdef BUTTON_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_enable <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         if (wr && bus.addr == 2'd0) begin
            irq_enable <= bus.wdata[2];
         end
         irq_q <= pending & irq_enable;
      end
   end

   assign bus.irq = irq_q;

   logic unused_wdata;
   assign unused_wdata = ^{bus.wdata[31:3], bus.wdata[0]};
`else
   assign irq_enable = 1'b0;
   assign bus.irq    = 1'b0;

   logic unused_wdata;
   assign unused_wdata = ^{bus.wdata[31:2], bus.wdata[0]};
`endif
endmodule

// File: tb/tb_button_input_peripheral.sv
// Directed bench for button_input_peripheral: latency, glitches, collisions,
// saturation on a narrow-counter instance, and the optional interrupt.
module tb_button_input_peripheral;
   logic       clk = 1'b0;
   logic       reset;
   logic       button_n;
   logic       button2_n;
   logic [9:0] switches;
   int         checks = 0;
   int         errors = 0;

`ifdef BUTTON_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   button_input_peripheral_if b1 ();
   button_input_peripheral_if b2 ();

   button_input_peripheral #(.DEBOUNCE_CYCLES(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .button_n(button_n),
      .switches(switches), .bus(b1.slave)
   );

   button_input_peripheral #(.DEBOUNCE_CYCLES(16), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .button_n(button2_n),
      .switches(switches), .bus(b2.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input bit d2, input logic [1:0] a, input logic [31:0] d);
      if (d2) begin
         b2.sel = 1'b1; b2.we = 1'b1; b2.addr = a; b2.wdata = d;
      end else begin
         b1.sel = 1'b1; b1.we = 1'b1; b1.addr = a; b1.wdata = d;
      end
      tick();
      b1.sel = 1'b0; b2.sel = 1'b0;
      b1.we = 1'b0; b2.we = 1'b0;
   endtask

   task automatic rd(input bit d2, input logic [1:0] a);
      if (d2) begin
         b2.sel = 1'b1; b2.we = 1'b0; b2.addr = a;
      end else begin
         b1.sel = 1'b1; b1.we = 1'b0; b1.addr = a;
      end
      tick();
      b1.sel = 1'b0; b2.sel = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      button_n = 1'b1;
      button2_n = 1'b1;
      switches = 10'h2A5;
      b1.sel = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
      b2.sel = 1'b0; b2.we = 1'b0; b2.addr = '0; b2.wdata = '0;
      tick();
      tick();
      check("rst_rdata", b1.rdata, 32'h0);
      check("rst_irq", {31'd0, b1.irq}, 32'h0);
      reset = 1'b0;
      repeat (3) tick();

      rd(0, 2'd2); check("rd_switches", b1.rdata, 32'h2A5);
      rd(0, 2'd0); check("rd_status0", b1.rdata, 32'h0);
      rd(0, 2'd1); check("rd_count0", b1.rdata, 32'h0);

      // Continuous STATUS reads; rdata shows the state one edge behind.
      button_n = 1'b0;
      b1.sel = 1'b1; b1.we = 1'b0; b1.addr = 2'd0;
      repeat (18) tick();
      check("lat_before", b1.rdata, 32'h0);
      tick();
      check("lat_edge", b1.rdata, 32'h1);
      tick();
      check("pend_set", b1.rdata, 32'h3);
      b1.sel = 1'b0;
      repeat (80) tick();
      rd(0, 2'd1); check("count_1", b1.rdata, 32'h1);
      button_n = 1'b1;
      repeat (100) tick();
      rd(0, 2'd1); check("release_noinc", b1.rdata, 32'h1);
      button_n = 1'b0;
      repeat (100) tick();
      button_n = 1'b1;
      repeat (100) tick();
      rd(0, 2'd1); check("count_2", b1.rdata, 32'h2);
      rd(0, 2'd0); check("status_released", b1.rdata, 32'h2);

      wr(0, 2'd0, 32'h2);
      rd(0, 2'd0); check("pend_clear", b1.rdata, 32'h0);
      wr(0, 2'd1, 32'hDEAD);
      rd(0, 2'd1); check("count_clear", b1.rdata, 32'h0);

      for (int g = 0; g < 3; g++) begin
         button_n = 1'b0;
         repeat (g == 0 ? 1 : (g == 1 ? 5 : 15)) tick();
         button_n = 1'b1;
         repeat (20) tick();
      end
      rd(0, 2'd0); check("glitch_status", b1.rdata, 32'h0);
      rd(0, 2'd1); check("glitch_count", b1.rdata, 32'h0);

      // Press event lands on the 19th edge after driving the button.
      button_n = 1'b0;
      repeat (18) tick();
      wr(0, 2'd0, 32'h2);
      rd(0, 2'd0); check("clr_vs_event", b1.rdata, 32'h3);
      button_n = 1'b1;
      repeat (40) tick();
      rd(0, 2'd0); check("pend_sticky", b1.rdata, 32'h2);

      button_n = 1'b0;
      repeat (18) tick();
      wr(0, 2'd1, 32'h0);
      rd(0, 2'd1); check("cntwr_vs_event", b1.rdata, 32'h1);
      button_n = 1'b1;
      repeat (40) tick();

      button_n = 1'b0;
      repeat (18) tick();
      rd(0, 2'd1); check("rd_event_pre", b1.rdata, 32'h1);
      rd(0, 2'd1); check("rd_event_post", b1.rdata, 32'h2);
      button_n = 1'b1;
      repeat (40) tick();

      rd(0, 2'd2); check("sw_again", b1.rdata, 32'h2A5);
      wr(0, 2'd0, 32'h2);
      check("rdata_hold", b1.rdata, 32'h2A5);
      rd(0, 2'd3); check("reserved_rd", b1.rdata, 32'h0);
      wr(0, 2'd2, 32'hFFFF);
      switches = 10'h15A;
      repeat (3) tick();
      rd(0, 2'd2); check("sw_new", b1.rdata, 32'h15A);

      for (int p = 0; p < 5; p++) begin
         button2_n = 1'b0;
         repeat (30) tick();
         button2_n = 1'b1;
         repeat (30) tick();
      end
      rd(1, 2'd1); check("sat_count", b2.rdata, 32'h3);
      wr(1, 2'd1, 32'h5);
      rd(1, 2'd1); check("sat_clear", b2.rdata, 32'h0);

      wr(0, 2'd0, 32'h4);
      rd(0, 2'd0); check("irqen_rd", b1.rdata, IRQ ? 32'h4 : 32'h0);
      check("irq_idle", {31'd0, b1.irq}, 32'h0);
      button_n = 1'b0;
      repeat (19) tick();
      check("irq_pend_edge", {31'd0, b1.irq}, 32'h0);
      tick();
      check("irq_set", {31'd0, b1.irq}, {31'd0, IRQ});
      wr(0, 2'd0, 32'h6);
      check("irq_clr_edge", {31'd0, b1.irq}, {31'd0, IRQ});
      tick();
      check("irq_cleared", {31'd0, b1.irq}, 32'h0);
      rd(0, 2'd0); check("status_final", b1.rdata, IRQ ? 32'h5 : 32'h1);
      button_n = 1'b1;
      repeat (40) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
